rst_release_seq: RTL and testbench
==================================

# rst_release_seq

Reset-release sequencer that generates the downstream block reset `dut_rst` and the qualifying `ready` flag. After a minimum hold, it waits for a stable `lock` input. It then raises `ready` while still holding `dut_rst`, and releases `dut_rst` a fixed number of cycles later. Consumers and their assertion benches rely on the contract "`dut_rst` stays high until `ready` is high". With `lock` present, the strong form of this contract also holds. Without `lock`, the sequencer parks in a fault state, where only the weak form holds.

## Interface
- `MIN_HOLD`, 8: cycles `dut_rst` is held unconditionally after `rst` release or lock loss; must be ≥1.
- `LOCK_STABLE`, 4: consecutive sampled-high `lock` cycles required; must be ≥1.
- `OVERLAP`, 2: cycles with `ready`=1 and `dut_rst`=1 before release; 0 means `dut_rst` drops in the same cycle `ready` rises.
- `TIMEOUT`, 64: maximum cycles in WAIT_LOCK before FAULT; must be > `LOCK_STABLE`.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `lock` in 1: PLL/upstream-ready indication; async-safe (already synchronised upstream).
- `dut_rst` out 1: downstream reset, active-high.
- `ready` out 1: downstream-ready qualifier.
- `timeout_err` out 1: sticky fault flag.
- `lock_loss_cnt` out 8: saturating count of lock losses in RUN.
- `state_o` out 3: current state encoding, for debug and bench.

## Operation
- States, with encoding `state_o`: HOLD=0, WAIT_LOCK=1, OVERLAP=2, RUN=3, FAULT=4. All outputs are decoded from the state register (Moore), with no combinational path from `lock`.
- Outputs per state:
  - HOLD: `dut_rst`=1, `ready`=0.
  - WAIT_LOCK: `dut_rst`=1, `ready`=0.
  - OVERLAP: `dut_rst`=1, `ready`=1.
  - RUN: `dut_rst`=0, `ready`=1.
  - FAULT: `dut_rst`=1, `ready`=0, `timeout_err`=1.
- Reset (`rst`=1 at posedge):
  - state ← HOLD and all counters ← 0.
  - `dut_rst`=1, `ready`=0, `timeout_err`=0, `lock_loss_cnt`=0.
  - `rst` overrides every other event, in any state, including mid-OVERLAP and FAULT.
- HOLD:
  - A hold counter increments each cycle.
  - After `MIN_HOLD` cycles in HOLD, go to WAIT_LOCK.
  - `lock` is ignored in HOLD.
- WAIT_LOCK:
  - The stability counter increments when `lock`=1 and clears to 0 when `lock`=0 (a glitch restarts the count).
  - The timeout counter increments every cycle regardless of `lock`.
  - Stability count reaching `LOCK_STABLE` → OVERLAP, or → RUN if `OVERLAP`=0.
  - Timeout count reaching `TIMEOUT` → FAULT.
  - If both occur in the same cycle, the stability condition wins.
- OVERLAP:
  - Stay for exactly `OVERLAP` cycles, then go to RUN.
  - `lock` falling here → HOLD immediately; `lock_loss_cnt` is not incremented.
- RUN:
  - `lock`=0 sampled → HOLD next cycle.
  - `lock_loss_cnt` increments, saturating at 255.
- FAULT: terminal until `rst`; `lock` is ignored.
- Counter widths: `$clog2(max(MIN_HOLD,TIMEOUT,OVERLAP)+1)`. No counter wraps; each counter is cleared on state entry.
- Invariant: whenever `dut_rst` goes 1→0, `ready` was already 1 in the previous cycle (or, with `OVERLAP`=0, rises in the same cycle). `ready` never rises without having passed through WAIT_LOCK.

## Timing
- Cycle numbering: cycle 0 is the first posedge at which `rst` is sampled 0.
- With `lock` constantly 1:
  - HOLD occupies cycles 0..`MIN_HOLD`-1.
  - `ready` is high from cycle `MIN_HOLD`+`LOCK_STABLE`.
  - `dut_rst` is low from cycle `MIN_HOLD`+`LOCK_STABLE`+`OVERLAP`.
  - Defaults: `ready` high at 12, `dut_rst` low at 14.
- With `lock` constantly 0: `timeout_err`=1 from cycle `MIN_HOLD`+`TIMEOUT` (default 72).
- Lock drop observed at a RUN posedge: the next cycle shows `dut_rst`=1 and `ready`=0 (1-cycle latency), followed by a full re-sequence.

## Test plan
- Defaults, `lock`=1 throughout → `ready` rises at cycle 12, `dut_rst` falls at 14, `timeout_err`=0; bench asserts `dut_rst s_until ready`.
- `lock`=0 throughout → `state_o`=4 and `timeout_err`=1 at cycle 72; `dut_rst`=1 and `ready`=0 through cycle 200; `until` passes, `s_until` fails.
- `lock` 1 at cycles 8–9, 0 at cycle 10, 1 from cycle 11 → stability restarts; `ready` at cycle 15, `dut_rst` low at 17.
- In RUN, `lock`=0 for one cycle at cycle 30 → `dut_rst`=1 and `ready`=0 at 31, `lock_loss_cnt`=1; with `lock` back high, `ready` rises again at 43.
- `rst` pulsed at cycle 13 (mid-OVERLAP) → `ready`=0 and `dut_rst`=1 the next cycle, `state_o`=0; sequence restarts at cycle 0.
- `OVERLAP`=0, `lock`=1 → `ready` rises and `dut_rst` falls together at cycle 12; `lock` held 0 until 500 with `TIMEOUT`=64 → `lock_loss_cnt` stays 0.

Source files
------------

// File: rtl/rst_release_seq.sv
// Reset-release sequencer: holds the downstream reset, waits for a stable lock,
// raises ready ahead of releasing dut_rst, and parks in a sticky fault on lock timeout.
module rst_release_seq #(
    parameter int unsigned MIN_HOLD    = 8,
    parameter int unsigned LOCK_STABLE = 4,
    parameter int unsigned OVERLAP     = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lock,
    output logic       dut_rst,
    output logic       ready,
    output logic       timeout_err,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] state_o
);

    localparam int unsigned MAX_HT  = (MIN_HOLD > TIMEOUT) ? MIN_HOLD : TIMEOUT;
    localparam int unsigned CNT_MAX = (MAX_HT > OVERLAP) ? MAX_HT : OVERLAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] S_HOLD      = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_OVERLAP   = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    logic [2:0]       state_q, state_n;
    logic [CNT_W-1:0] phase_q, phase_n;
    logic [CNT_W-1:0] stab_q, stab_n;
    logic [7:0]       loss_n;
    logic             dut_rst_n, ready_n, timeout_err_n;

    // phase_q counts cycles already spent in the current state; stab_q counts the lock streak
    always_comb begin
        state_n = state_q;
        phase_n = phase_q;
        stab_n  = '0;
        loss_n  = lock_loss_cnt;
        case (state_q)
            S_HOLD: begin
                if (phase_q == CNT_W'(MIN_HOLD - 1)) begin
                    state_n = S_WAIT_LOCK;
                    phase_n = '0;
                end else begin
                    phase_n = phase_q + CNT_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                phase_n = phase_q + CNT_W'(1);
                stab_n  = lock ? stab_q + CNT_W'(1) : '0;
                // a completed lock streak wins over a simultaneous timeout
                if (lock && (stab_q == CNT_W'(LOCK_STABLE - 1))) begin
                    state_n = (OVERLAP == 0) ? S_RUN : S_OVERLAP;
                    phase_n = '0;
                    stab_n  = '0;
                end else if (phase_q == CNT_W'(TIMEOUT - 1)) begin
                    state_n = S_FAULT;
                    phase_n = '0;
                    stab_n  = '0;
                end
            end
            S_OVERLAP: begin
                if (!lock) begin
                    state_n = S_HOLD;
                    phase_n = '0;
                end else if (phase_q == CNT_W'(OVERLAP - 1)) begin
                    state_n = S_RUN;
                    phase_n = '0;
                end else begin
                    phase_n = phase_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (!lock) begin
                    state_n = S_HOLD;
                    phase_n = '0;
                    if (lock_loss_cnt != 8'hFF) begin
                        loss_n = lock_loss_cnt + 8'd1;
                    end
                end
            end
            S_FAULT: begin
                state_n = S_FAULT;
            end
            default: begin
                state_n = S_HOLD;
                phase_n = '0;
            end
        endcase

        dut_rst_n     = (state_n != S_RUN);
        ready_n       = (state_n == S_OVERLAP) || (state_n == S_RUN);
        timeout_err_n = (state_n == S_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_HOLD;
            phase_q       <= '0;
            stab_q        <= '0;
            dut_rst       <= 1'b1;
            ready         <= 1'b0;
            timeout_err   <= 1'b0;
            lock_loss_cnt <= 8'd0;
        end else begin
            state_q       <= state_n;
            phase_q       <= phase_n;
            stab_q        <= stab_n;
            dut_rst       <= dut_rst_n;
            ready         <= ready_n;
            timeout_err   <= timeout_err_n;
            lock_loss_cnt <= loss_n;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_rst_release_seq.sv
// Bench for rst_release_seq: two instances (OVERLAP=2 and OVERLAP=0) share rst/lock and
// are compared every cycle against a phase/elapsed-time model plus fixed timing expectations.
module tb_rst_release_seq;

    localparam int MH = 8;
    localparam int LS = 4;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       dut_rst_a, ready_a, terr_a, dut_rst_b, ready_b, terr_b;
    logic [7:0] loss_a, loss_b;
    logic [2:0] state_a, state_b;
    logic [13:0] obs_a, obs_b;

    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;

    // model: current phase (spec state number), cycles elapsed in phase, lock streak, losses
    int m_st[2];
    int m_el[2];
    int m_streak[2];
    int m_loss[2];

    always #5 clk = ~clk;

    rst_release_seq #(.MIN_HOLD(MH), .LOCK_STABLE(LS), .OVERLAP(2), .TIMEOUT(TO)) dut_a (
        .clk(clk), .rst(rst), .lock(lock), .dut_rst(dut_rst_a), .ready(ready_a),
        .timeout_err(terr_a), .lock_loss_cnt(loss_a), .state_o(state_a)
    );

    rst_release_seq #(.MIN_HOLD(MH), .LOCK_STABLE(LS), .OVERLAP(0), .TIMEOUT(TO)) dut_b (
        .clk(clk), .rst(rst), .lock(lock), .dut_rst(dut_rst_b), .ready(ready_b),
        .timeout_err(terr_b), .lock_loss_cnt(loss_b), .state_o(state_b)
    );

    assign obs_a = {state_a, dut_rst_a, ready_a, terr_a, loss_a};
    assign obs_b = {state_b, dut_rst_b, ready_b, terr_b, loss_b};

    function automatic int ovl_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic void go(input int i, input int s);
        m_st[i]     = s;
        m_el[i]     = 0;
        m_streak[i] = 0;
    endfunction

    function automatic void model_step(input logic r, input logic l);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                go(i, 0);
                m_loss[i] = 0;
            end else begin
                m_el[i]++;
                case (m_st[i])
                    0: if (m_el[i] == MH) go(i, 1);
                    1: begin
                        m_streak[i] = l ? m_streak[i] + 1 : 0;
                        if (m_streak[i] == LS) go(i, (ovl_of(i) > 0) ? 2 : 3);
                        else if (m_el[i] == TO) go(i, 4);
                    end
                    2: begin
                        if (!l) go(i, 0);
                        else if (m_el[i] == ovl_of(i)) go(i, 3);
                    end
                    3: begin
                        if (!l) begin
                            if (m_loss[i] < 255) m_loss[i]++;
                            go(i, 0);
                        end
                    end
                    default: ;
                endcase
            end
        end
    endfunction

    function automatic logic [13:0] exp_vec(input int i);
        int s;
        s = m_st[i];
        return {3'(s), 1'(s != 3), 1'((s == 2) || (s == 3)), 1'(s == 4), 8'(m_loss[i])};
    endfunction

    // drive inputs for the current cycle, advance one clock, observe on the falling edge
    task automatic tick(input logic r, input logic l);
        rst  = r;
        lock = l;
        @(posedge clk);
        model_step(r, l);
        @(negedge clk);
        cyc = r ? 0 : cyc + 1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        n_run++;
        if (obs_a !== {3'd0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_a got=%h exp=%h", obs_a, {3'd0, 1'b1, 1'b0, 1'b0, 8'd0});
        end
        n_run++;
        if (obs_b !== {3'd0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_b got=%h exp=%h", obs_b, {3'd0, 1'b1, 1'b0, 1'b0, 8'd0});
        end
    endtask

    task automatic test_lock_high();
        int fr = -1, fd = -1, frb = -1, fdb = -1, until_viol = 0;
        tick(1'b1, 1'b1);
        for (int k = 0; k < 25; k++) begin
            n_run += 2;
            if (obs_a !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL high_model_a cyc=%0d got=%h exp=%h", cyc, obs_a, exp_vec(0));
            end
            if (obs_b !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL high_model_b cyc=%0d got=%h exp=%h", cyc, obs_b, exp_vec(1));
            end
            if (ready_a === 1'b1 && fr < 0) fr = cyc;
            if (dut_rst_a === 1'b0 && fd < 0) fd = cyc;
            if (ready_b === 1'b1 && frb < 0) frb = cyc;
            if (dut_rst_b === 1'b0 && fdb < 0) fdb = cyc;
            if (dut_rst_a !== 1'b1 && fr < 0) until_viol++;
            tick(1'b0, 1'b1);
        end
        n_run++;
        if (fr != 12) begin n_fail++; $display("FAIL high_ready_a got=%0d exp=12", fr); end
        n_run++;
        if (fd != 14) begin n_fail++; $display("FAIL high_release_a got=%0d exp=14", fd); end
        n_run++;
        if (frb != 12 || fdb != 12) begin
            n_fail++;
            $display("FAIL high_ov0_b ready=%0d release=%0d exp=12/12", frb, fdb);
        end
        n_run++;
        if (until_viol != 0 || terr_a !== 1'b0) begin
            n_fail++;
            $display("FAIL high_s_until viol=%0d terr=%b exp=0/0", until_viol, terr_a);
        end
    endtask

    task automatic test_lock_low();
        int viol = 0, seen_ready = 0;
        tick(1'b1, 1'b0);
        for (int k = 0; k <= 500; k++) begin
            n_run += 2;
            if (obs_a !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL low_model_a cyc=%0d got=%h exp=%h", cyc, obs_a, exp_vec(0));
            end
            if (obs_b !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL low_model_b cyc=%0d got=%h exp=%h", cyc, obs_b, exp_vec(1));
            end
            if (cyc == 71) begin
                n_run++;
                if (terr_a !== 1'b0) begin n_fail++; $display("FAIL low_terr71 got=%b exp=0", terr_a); end
            end
            if (cyc == 72) begin
                n_run++;
                if (state_a !== 3'd4 || terr_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL low_fault72 state=%0d terr=%b exp=4/1", state_a, terr_a);
                end
            end
            if (cyc <= 200 && (dut_rst_a !== 1'b1 || ready_a !== 1'b0)) viol++;
            if (ready_a === 1'b1) seen_ready++;
            tick(1'b0, 1'b0);
        end
        n_run++;
        if (viol != 0 || seen_ready != 0) begin
            n_fail++;
            $display("FAIL low_weak_until viol=%0d ready_seen=%0d exp=0/0", viol, seen_ready);
        end
        n_run++;
        if (loss_b !== 8'd0 || state_b !== 3'd4) begin
            n_fail++;
            $display("FAIL low_ov0_b loss=%0d state=%0d exp=0/4", loss_b, state_b);
        end
        tick(1'b1, 1'b1);
        n_run++;
        if (obs_a !== {3'd0, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL low_rst_from_fault got=%h exp=%h", obs_a, {3'd0, 1'b1, 1'b0, 1'b0, 8'd0});
        end
    endtask

    task automatic test_glitch();
        int fr = -1, fd = -1, frb = -1;
        logic l;
        tick(1'b1, 1'b0);
        for (int k = 0; k < 25; k++) begin
            n_run += 2;
            if (obs_a !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL glitch_model_a cyc=%0d got=%h exp=%h", cyc, obs_a, exp_vec(0));
            end
            if (obs_b !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL glitch_model_b cyc=%0d got=%h exp=%h", cyc, obs_b, exp_vec(1));
            end
            if (ready_a === 1'b1 && fr < 0) fr = cyc;
            if (dut_rst_a === 1'b0 && fd < 0) fd = cyc;
            if (ready_b === 1'b1 && frb < 0) frb = cyc;
            if (cyc < 8) l = 1'($urandom_range(0, 1));
            else l = (cyc == 10) ? 1'b0 : 1'b1;
            tick(1'b0, l);
        end
        n_run++;
        if (fr != 15 || fd != 17) begin
            n_fail++;
            $display("FAIL glitch_a ready=%0d release=%0d exp=15/17", fr, fd);
        end
        n_run++;
        if (frb != 15) begin n_fail++; $display("FAIL glitch_b ready=%0d exp=15", frb); end
    endtask

    task automatic test_lock_loss();
        int fr2 = -1, fd2 = -1, frb2 = -1;
        tick(1'b1, 1'b1);
        for (int k = 0; k <= 50; k++) begin
            n_run += 2;
            if (obs_a !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL loss_model_a cyc=%0d got=%h exp=%h", cyc, obs_a, exp_vec(0));
            end
            if (obs_b !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL loss_model_b cyc=%0d got=%h exp=%h", cyc, obs_b, exp_vec(1));
            end
            if (cyc == 31) begin
                n_run++;
                if (dut_rst_a !== 1'b1 || ready_a !== 1'b0 || loss_a !== 8'd1 || loss_b !== 8'd1) begin
                    n_fail++;
                    $display("FAIL loss_c31 rst=%b rdy=%b la=%0d lb=%0d exp=1/0/1/1",
                             dut_rst_a, ready_a, loss_a, loss_b);
                end
            end
            if (cyc > 31 && ready_a === 1'b1 && fr2 < 0) fr2 = cyc;
            if (cyc > 31 && dut_rst_a === 1'b0 && fd2 < 0) fd2 = cyc;
            if (cyc > 31 && ready_b === 1'b1 && frb2 < 0) frb2 = cyc;
            tick(1'b0, (cyc == 30) ? 1'b0 : 1'b1);
        end
        n_run++;
        if (fr2 != 43 || fd2 != 45 || frb2 != 43) begin
            n_fail++;
            $display("FAIL loss_reseq ready_a=%0d release_a=%0d ready_b=%0d exp=43/45/43", fr2, fd2, frb2);
        end
    endtask

    task automatic test_rst_mid_overlap();
        int fr = -1;
        tick(1'b1, 1'b1);
        while (cyc < 13) tick(1'b0, 1'b1);
        n_run++;
        if (state_a !== 3'd2 || ready_a !== 1'b1 || dut_rst_a !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ovl_c13 state=%0d rdy=%b rst=%b exp=2/1/1", state_a, ready_a, dut_rst_a);
        end
        tick(1'b1, 1'b1);
        n_run++;
        if (state_a !== 3'd0 || ready_a !== 1'b0 || dut_rst_a !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ovl_rst state=%0d rdy=%b rst=%b exp=0/0/1", state_a, ready_a, dut_rst_a);
        end
        for (int k = 0; k < 16; k++) begin
            n_run++;
            if (obs_a !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL mid_ovl_model_a cyc=%0d got=%h exp=%h", cyc, obs_a, exp_vec(0));
            end
            if (ready_a === 1'b1 && fr < 0) fr = cyc;
            tick(1'b0, 1'b1);
        end
        n_run++;
        if (fr != 12) begin n_fail++; $display("FAIL mid_ovl_restart ready=%0d exp=12", fr); end
    endtask

    task automatic test_saturation();
        int budget;
        tick(1'b1, 1'b1);
        for (int e = 0; e < 260; e++) begin
            budget = 0;
            while (state_a !== 3'd3 && budget < 40) begin
                n_run += 2;
                if (obs_a !== exp_vec(0)) begin
                    n_fail++;
                    $display("FAIL sat_model_a cyc=%0d got=%h exp=%h", cyc, obs_a, exp_vec(0));
                end
                if (obs_b !== exp_vec(1)) begin
                    n_fail++;
                    $display("FAIL sat_model_b cyc=%0d got=%h exp=%h", cyc, obs_b, exp_vec(1));
                end
                tick(1'b0, 1'b1);
                budget++;
            end
            n_run++;
            if (state_a !== 3'd3) begin
                n_fail++;
                $display("FAIL sat_wait_run event=%0d state=%0d exp=3", e, state_a);
                break;
            end
            tick(1'b0, 1'b0);
            if (e == 9) begin
                n_run++;
                if (loss_a !== 8'd10) begin n_fail++; $display("FAIL sat_mid got=%0d exp=10", loss_a); end
            end
        end
        n_run++;
        if (loss_a !== 8'd255 || loss_b !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_final loss_a=%0d loss_b=%0d exp=255/255", loss_a, loss_b);
        end
    endtask

    task automatic test_random();
        logic l = 1'b1, r;
        logic prev_rst_a = 1'b1, prev_rdy_a = 1'b0, prev_rst_b = 1'b1;
        tick(1'b1, 1'b1);
        for (int k = 0; k < 4000; k++) begin
            n_run += 2;
            if (obs_a !== exp_vec(0)) begin
                n_fail++;
                $display("FAIL rand_model_a k=%0d got=%h exp=%h", k, obs_a, exp_vec(0));
            end
            if (obs_b !== exp_vec(1)) begin
                n_fail++;
                $display("FAIL rand_model_b k=%0d got=%h exp=%h", k, obs_b, exp_vec(1));
            end
            if (prev_rst_a === 1'b1 && dut_rst_a === 1'b0) begin
                n_run++;
                if (prev_rdy_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_release_a k=%0d prev_ready=%b exp=1", k, prev_rdy_a);
                end
            end
            if (prev_rst_b === 1'b1 && dut_rst_b === 1'b0) begin
                n_run++;
                if (ready_b !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_release_b k=%0d ready=%b exp=1", k, ready_b);
                end
            end
            prev_rst_a = dut_rst_a;
            prev_rdy_a = ready_a;
            prev_rst_b = dut_rst_b;
            if (l) l = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            else   l = ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0;
            r = ($urandom_range(0, 499) == 0);
            tick(r, l);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_lock_high();
        test_lock_low();
        test_glitch();
        test_lock_loss();
        test_rst_mid_overlap();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
